// File: rtl/rc_pkg.sv
// Shared types and helpers for the adder residue checker.
// Residues are 2-bit mod-3 values that never hold 3.
package rc_pkg;

    localparam int RC_WIDTH = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } rc_state_t;

    // Both operands must already be reduced (0..2), so one conditional subtract suffices.
    function automatic logic [1:0] mod3(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] t;
        t = {1'b0, x} + {1'b0, y};
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

endpackage

// File: rtl/mod3_residue.sv
// Combinational N-bit value -> mod-3 residue.
// Each bit pair carries weights 1 and 2, so a pair's residue is its own value with 3 folded to 0.
module mod3_residue #(
    parameter int N = 8
) (
    input  logic [N-1:0] value,
    output logic [1:0]   residue
);
    import rc_pkg::*;

    localparam int P = (N + 1) / 2;

    logic [2*P-1:0] padded;

    always_comb begin
        padded         = '0;
        padded[N-1:0]  = value;
        residue        = 2'd0;
        for (int i = 0; i < P; i++) begin
            residue = mod3(residue, (padded[2*i +: 2] == 2'd3) ? 2'd0 : padded[2*i +: 2]);
        end
    end

endmodule

// File: rtl/rc_residue_checker.sv
// Mod-3 residue checker for the ripple-carry adder: two-stage ready-propagating pipeline,
// saturating mismatch counter and a latched fault that blocks new input until cleared.
//
//   state | meaning
//   RUN   | accepting transactions, counting mismatches
//   FAULT | count reached threshold; input blocked, in-flight work drains
module rc_residue_checker
    import rc_pkg::*;
#(
    parameter int WIDTH        = RC_WIDTH,
    parameter int ERR_CNT_W    = 8,
    parameter int FAULT_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     s,
    input  logic                 cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_sum,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 fault,
    input  logic                 clr_fault
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] THRESH  = ERR_CNT_W'(FAULT_THRESH);

    rc_state_t            state;
    logic                 s1_valid;
    logic [1:0]           s1_ra, s1_rb, s1_rs;
    logic                 s1_cin;
    logic [WIDTH:0]       s1_sum;
    logic [1:0]           ra, rb, rs;
    logic                 s2_load, s1_load, s1_advance, in_fire;
    logic                 mismatch, err_load;
    logic [ERR_CNT_W-1:0] cnt_next;

    mod3_residue #(.N(WIDTH))     u_res_a (.value(a),          .residue(ra));
    mod3_residue #(.N(WIDTH))     u_res_b (.value(b),          .residue(rb));
    mod3_residue #(.N(WIDTH + 1)) u_res_s (.value({cout, s}),  .residue(rs));

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign s1_load    = !s1_valid || s1_advance;
    assign in_ready   = !rst && (state == RUN) && s1_load;
    assign in_fire    = in_valid && in_ready;

    assign mismatch   = mod3(mod3(s1_ra, s1_rb), {1'b0, s1_cin}) != s1_rs;
    // Counting at the S2 load gives one increment per transaction however long it stalls.
    assign err_load   = s1_advance && mismatch;
    assign cnt_next   = (err_count == CNT_MAX) ? err_count : err_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ra    <= 2'd0;
            s1_rb    <= 2'd0;
            s1_rs    <= 2'd0;
            s1_cin   <= 1'b0;
            s1_sum   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_ra  <= ra;
                s1_rb  <= rb;
                s1_rs  <= rs;
                s1_cin <= cin;
                s1_sum <= {cout, s};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum <= s1_sum;
                out_err <= mismatch;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            err_count <= '0;
            fault     <= 1'b0;
        end else if (clr_fault) begin
            state     <= RUN;
            err_count <= '0;
            fault     <= 1'b0;
        end else begin
            if (err_load) begin
                err_count <= cnt_next;
            end
            case (state)
                RUN: begin
                    if (err_load && cnt_next == THRESH) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT: fault <= 1'b1;
                default: begin
                    state <= RUN;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc_residue_checker.sv
// Directed bench for rc_residue_checker: queue-based reference model checked every cycle,
// plus literal expectations per scenario and a second instance for counter saturation.
module tb_rc_residue_checker;

    localparam int THRESH = 4;

    typedef struct {
        logic [8:0] sum;
        logic       err;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid, in_ready, cin, cout, out_valid, out_ready, out_err, fault, clr_fault;
    logic [7:0] a, b, s, err_count;
    logic [8:0] out_sum;

    logic       in_valid2, in_ready2, cin2, cout2, out_valid2, out_err2, fault2;
    logic       out_ready2, clr_fault2;
    logic [7:0] a2, b2, s2, err_count2;
    logic [8:0] out_sum2;

    txn_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   acc_total = 0;
    int   outv_seen = 0;
    int   sat_seen = 0;
    int   exp_cnt = 0;
    logic exp_fault = 1'b0;
    logic prev_clr = 1'b0;
    logic prev_ov = 1'b0;
    logic prev_or = 1'b0;
    int   base;

    rc_residue_checker #(.WIDTH(8), .ERR_CNT_W(8), .FAULT_THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
        .err_count(err_count), .fault(fault), .clr_fault(clr_fault)
    );

    rc_residue_checker #(.WIDTH(8), .ERR_CNT_W(8), .FAULT_THRESH(255)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .s(s2), .cout(cout2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2), .out_err(out_err2),
        .err_count(err_count2), .fault(fault2), .clr_fault(clr_fault2)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endfunction

    function automatic txn_t model(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                                   input logic [7:0] si, input logic co);
        txn_t t;
        int   lhs, rhs;
        lhs   = (int'(ai) + int'(bi) + int'(ci)) % 3;
        rhs   = int'({co, si}) % 3;
        t.sum = {co, si};
        t.err = (lhs != rhs);
        return t;
    endfunction

    // Reference: one queue entry per accepted transaction; counter bumps when a new result appears.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt   = 0;
            exp_fault = 1'b0;
            prev_clr  = 1'b0;
            prev_ov   = 1'b0;
            prev_or   = 1'b0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_in_ready", int'(in_ready), 0);
        end else begin
            logic is_new;
            if (prev_clr) begin
                exp_cnt   = 0;
                exp_fault = 1'b0;
            end
            is_new = out_valid && !(prev_ov && !prev_or);
            if (prev_ov && !prev_or) chk("out_valid_hold", int'(out_valid), 1);
            if (is_new && q.size() > 0 && q[0].err && !prev_clr) begin
                exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                if (!exp_fault && exp_cnt == THRESH) exp_fault = 1'b1;
            end
            if (out_valid) begin
                outv_seen++;
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_output: out_valid=1 with nothing pending, out_sum=0x%0h at %0t",
                             out_sum, $time);
                end else begin
                    chk("out_sum", int'(out_sum), int'(q[0].sum));
                    chk("out_err", int'(out_err), int'(q[0].err));
                end
            end
            chk("err_count", int'(err_count), exp_cnt);
            chk("fault", int'(fault), int'(exp_fault));
            if (exp_fault) chk("in_ready_in_fault", int'(in_ready), 0);
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                acc_total++;
                q.push_back(model(a, b, cin, s, cout));
            end
            prev_clr = clr_fault;
            prev_ov  = out_valid;
            prev_or  = out_ready;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2) begin
            if (out_err2) sat_seen++;
            chk("sat_out_sum", int'(out_sum2), 9'h001);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                        input logic [7:0] si, input logic co);
        int waited = 0;
        a = ai; b = bi; cin = ci; s = si; cout = co;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles at %0t", waited, $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; a = 0; b = 0; cin = 0; s = 0; cout = 0; out_ready = 1; clr_fault = 0;
        in_valid2 = 0; a2 = 0; b2 = 0; cin2 = 0; s2 = 8'h01; cout2 = 0; out_ready2 = 1; clr_fault2 = 0;
        rst = 1'b1;
        step(2);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_sum", int'(out_sum), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_fault", int'(fault), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", int'(in_ready), 1);

        chk("model_pin_ok", int'(model(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1).err), 0);
        chk("model_pin_bad", int'(model(8'hFF, 8'h01, 1'b1, 8'h03, 1'b1).err), 1);

        // basic transfer and latency
        push(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        chk("t1_not_before_s2", int'(out_valid), 0);
        step(1);
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_out_sum", int'(out_sum), 9'h010);
        chk("t1_out_err", int'(out_err), 0);
        chk("t1_err_count", int'(err_count), 0);
        step(2);

        // carry wrap, then a bit-1 flip
        push(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1);
        push(8'hFF, 8'h01, 1'b1, 8'h03, 1'b1);
        chk("t2_sum_ok", int'(out_sum), 9'h101);
        chk("t2_err_ok", int'(out_err), 0);
        step(1);
        chk("t2_sum_bad", int'(out_sum), 9'h103);
        chk("t2_err_bad", int'(out_err), 1);
        chk("t2_err_count", int'(err_count), 1);
        step(3);

        // backpressure
        out_ready = 1'b0;
        base = acc_total;
        fork
            begin
                push(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
                push(8'h10, 8'h20, 1'b1, 8'h30, 1'b0);
                push(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
                push(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1);
            end
            begin
                step(6);
                chk("t3_in_ready_stalled", int'(in_ready), 0);
                chk("t3_accepted_while_stalled", acc_total - base, 2);
                out_ready = 1'b1;
            end
        join
        step(4);
        chk("t3_all_accepted", acc_total - base, 4);
        chk("t3_all_drained", q.size(), 0);
        chk("t3_err_count", int'(err_count), 2);

        // clear in RUN, then drive into FAULT
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("t4_clr_run_count", int'(err_count), 0);
        chk("t4_clr_run_fault", int'(fault), 0);
        for (int i = 1; i <= 4; i++) push(8'(i), 8'(i), 1'b0, 8'(2 * i + 1), 1'b0);
        step(3);
        chk("t4_err_count", int'(err_count), 4);
        chk("t4_fault", int'(fault), 1);
        chk("t4_in_ready", int'(in_ready), 0);
        base = acc_total;
        a = 8'h01; b = 8'h01; cin = 0; s = 8'h02; cout = 0;
        in_valid = 1'b1;
        step(3);
        in_valid = 1'b0;
        chk("t4_blocked", acc_total - base, 0);
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("t4_clr_fault", int'(fault), 0);
        chk("t4_clr_count", int'(err_count), 0);
        chk("t4_clr_in_ready", int'(in_ready), 1);

        // clear colliding with an increment
        push(8'h03, 8'h00, 1'b0, 8'h01, 1'b0);
        step(2);
        chk("t5_pre_count", int'(err_count), 1);
        push(8'h03, 8'h00, 1'b0, 8'h01, 1'b0);
        clr_fault = 1'b1;
        step(1);
        clr_fault = 1'b0;
        chk("t5_collide_valid", int'(out_valid), 1);
        chk("t5_collide_err", int'(out_err), 1);
        chk("t5_collide_count", int'(err_count), 0);
        step(2);

        // saturation on the second instance: every transaction is corrupt
        in_valid2 = 1'b1;
        step(300);
        in_valid2 = 1'b0;
        step(3);
        chk("sat_err_count", int'(err_count2), 255);
        chk("sat_fault", int'(fault2), 1);
        chk("sat_in_ready", int'(in_ready2), 0);
        chk("sat_errors_seen", sat_seen, 256);

        // reset with both stages full
        out_ready = 1'b0;
        push(8'h03, 8'h00, 1'b0, 8'h01, 1'b0);
        push(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        chk("t6_full_valid", int'(out_valid), 1);
        chk("t6_full_count", int'(err_count), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_err_count", int'(err_count), 0);
        chk("t6_rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        base = outv_seen;
        step(5);
        chk("t6_no_stale_output", outv_seen - base, 0);
        chk("t6_out_valid_idle", int'(out_valid), 0);
        push(8'h20, 8'h21, 1'b1, 8'h42, 1'b0);
        step(3);
        chk("t6_alive_after_reset", outv_seen - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
